// File: rtl/sa2_stream_ctrl.sv
// Stream controller for the 2x2 systolic array: loads a 4x4 operand and 3x3 kernel
// from a byte stream, runs the array with a timeout, then streams the 4 result bytes.
module sa2_stream_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] a11,
    output logic [7:0] a12,
    output logic [7:0] a13,
    output logic [7:0] a14,
    output logic [7:0] a21,
    output logic [7:0] a22,
    output logic [7:0] a23,
    output logic [7:0] a24,
    output logic [7:0] a31,
    output logic [7:0] a32,
    output logic [7:0] a33,
    output logic [7:0] a34,
    output logic [7:0] a41,
    output logic [7:0] a42,
    output logic [7:0] a43,
    output logic [7:0] a44,
    output logic [7:0] b11,
    output logic [7:0] b12,
    output logic [7:0] b13,
    output logic [7:0] b21,
    output logic [7:0] b22,
    output logic [7:0] b23,
    output logic [7:0] b31,
    output logic [7:0] b32,
    output logic [7:0] b33,
    output logic       active_sa2,
    input  logic       done_sa2,
    input  logic [7:0] c11,
    input  logic [7:0] c12,
    input  logic [7:0] c21,
    input  logic [7:0] c22,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       err_timeout
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, RUN, SEND} state_t;

    state_t          r_state;
    logic [4:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_oidx;
    logic [7:0]      r_a [16];
    logic [7:0]      r_b [9];
    logic [7:0]      r_c [4];
    logic            r_in_ready;
    logic            r_active;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_last;
    logic            r_err;
    logic            w_in_fire;

    assign w_in_fire = in_valid & r_in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= LOAD;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_oidx      <= '0;
            r_in_ready  <= 1'b0;
            r_active    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) r_a[i] <= '0;
            for (int unsigned i = 0; i < 9; i++)  r_b[i] <= '0;
            for (int unsigned i = 0; i < 4; i++)  r_c[i] <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        // Indices 16..24 map onto b via the low nibble (16 -> 0 .. 24 -> 8).
                        if (r_idx[4]) r_b[r_idx[3:0]] <= in_data;
                        else          r_a[r_idx[3:0]] <= in_data;
                        if (r_idx == 5'd0) r_err <= 1'b0;
                        if (r_idx == 5'd24) begin
                            r_idx      <= '0;
                            r_cnt      <= '0;
                            r_state    <= RUN;
                            r_in_ready <= 1'b0;
                            r_active   <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                RUN: begin
                    if (done_sa2) begin
                        r_c[0]      <= c11;
                        r_c[1]      <= c12;
                        r_c[2]      <= c21;
                        r_c[3]      <= c22;
                        r_active    <= 1'b0;
                        r_state     <= SEND;
                        r_oidx      <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= c11;
                        r_out_last  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err      <= 1'b1;
                        r_active   <= 1'b0;
                        r_state    <= LOAD;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (r_oidx == 2'd3) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_oidx      <= '0;
                            r_state     <= LOAD;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_oidx     <= r_oidx + 2'd1;
                            r_out_data <= r_c[r_oidx + 2'd1];
                            r_out_last <= (r_oidx == 2'd2);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign active_sa2  = r_active;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign err_timeout = r_err;

    assign a11 = r_a[0];
    assign a12 = r_a[1];
    assign a13 = r_a[2];
    assign a14 = r_a[3];
    assign a21 = r_a[4];
    assign a22 = r_a[5];
    assign a23 = r_a[6];
    assign a24 = r_a[7];
    assign a31 = r_a[8];
    assign a32 = r_a[9];
    assign a33 = r_a[10];
    assign a34 = r_a[11];
    assign a41 = r_a[12];
    assign a42 = r_a[13];
    assign a43 = r_a[14];
    assign a44 = r_a[15];
    assign b11 = r_b[0];
    assign b12 = r_b[1];
    assign b13 = r_b[2];
    assign b21 = r_b[3];
    assign b22 = r_b[4];
    assign b23 = r_b[5];
    assign b31 = r_b[6];
    assign b32 = r_b[7];
    assign b33 = r_b[8];

endmodule

// File: doc/sa2_stream_ctrl.md
SA2_STREAM_CTRL -- requirements
Module: sa2_stream_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles in RUN waiting for done_sa2.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 8): the operand byte stream.
REQ-005 SHALL have ports a11..a44, output, 8 each: the 4x4 operand registers, row-major.
REQ-006 SHALL have ports b11..b33, output, 8 each: the 3x3 kernel registers, row-major.
REQ-007 SHALL have port active_sa2, output, 1: the start/level request to the 2x2 array.
REQ-008 SHALL have ports done_sa2 (input, 1) and c11, c12, c21, c22 (input, 8 each): the array completion flag and result bytes.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 8) and out_last (output, 1): the result stream.
REQ-010 SHALL have port err_timeout, output, 1: sticky timeout flag.

Function
REQ-011 SHALL implement states LOAD, RUN, SEND, with LOAD as the reset state.
REQ-012 In LOAD: in_ready=1; byte accepted when in_valid&in_ready; load index 0-24 increments per accepted byte.
REQ-013 Byte index 0-15 SHALL write a11,a12,a13,a14,a21..a44 in order; index 16-24 writes b11..b33 in order.
REQ-014 On acceptance of index 24: index returns to 0 and state moves to RUN on the next cycle; in_ready SHALL be 0 in RUN and SEND.
REQ-015 a*/b* registers SHALL hold value outside LOAD writes; partially loaded frames retain old values in unwritten registers.
REQ-016 In RUN: active_sa2=1 every cycle; cycle counter counts from 0 on RUN entry.
REQ-017 done_sa2 sampled 1 in RUN: capture c11,c12,c21,c22 into internal result registers that edge, deassert active_sa2 next cycle, go to SEND.
REQ-018 Counter reaching TIMEOUT-1 without done_sa2: set err_timeout, drop active_sa2, return to LOAD; no results sent.
REQ-019 done_sa2 and timeout in the same cycle: done wins; err_timeout not set.
REQ-020 done_sa2 outside RUN SHALL be ignored; c* inputs only sampled per REQ-017.
REQ-021 In SEND: out_valid=1; out_data presents captured c11, c12, c21, c22 in that order; index advances on out_valid&out_ready.
REQ-022 out_data and out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 out_last=1 only with c22; on its transfer out_valid=0 next cycle and state returns to LOAD.
REQ-024 out_valid=0 and out_last=0 outside SEND.
REQ-025 err_timeout SHALL clear when the first byte (index 0) of the next frame is accepted.
REQ-026 Throughput: one input byte per cycle in LOAD; one output byte per cycle in SEND with out_ready held 1; no bubble cycles within a frame.
REQ-027 Minimum frame latency: last input byte accepted at cycle T -> active_sa2=1 at T+1.

Reset
REQ-028 reset=0 SHALL asynchronously force state LOAD, all indices/counters 0, active_sa2=0, out_valid=0, out_last=0, out_data=0, err_timeout=0, all a*/b*/result registers 0.
REQ-029 in_ready SHALL be 0 while reset=0 and 1 from the first clock edge after reset release.
REQ-030 Reset during RUN or SEND SHALL abandon the frame; no partial output after release.

Verification
REQ-031 Stream bytes 1..25 back-to-back -> a11=1, a44=16, b11=17, b33=25, active_sa2=1 the cycle after byte 25.
REQ-032 done_sa2 pulsed 5 cycles into RUN with c11=8'h10, c12=8'h20, c21=8'h30, c22=8'h40, out_ready=1 -> out_data 10,20,30,40 on consecutive cycles, out_last with 40, then in_ready=1.
REQ-033 out_ready toggled 0/1 each cycle in SEND -> each byte held stable while stalled, 4 transfers in 8 cycles, order unchanged.
REQ-034 done_sa2 never asserted, TIMEOUT=64 -> active_sa2 falls after 64 RUN cycles, err_timeout=1, out_valid stays 0; next accepted byte clears err_timeout.
REQ-035 reset=0 asserted mid-SEND after c11 transferred -> all outputs zero immediately, no further out_valid, next frame loads from index 0.
REQ-036 done_sa2=1 held in LOAD while bytes stream -> ignored; RUN behaves per REQ-017 on the next done_sa2 sample.
